// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//
// Pipeline hazard detection and forwarding control for a five-stage in-order
// core. The unit keeps a three-entry scoreboard that mirrors the EX, MEM and
// WB stages. It compares the ID-stage sources against that scoreboard and
// produces four kinds of result:
//   * a one-cycle load-use stall: ID control is zeroed, and PC and IF/ID are
//     held.
//   * operand forwarding selects for Rn and Rm.
//   * an IF/ID flush for a taken branch. The flush is suppressed while a
//     stall holds ID, so the branch resolves again on the next cycle.
//   * saturating counters for stall cycles and flushes.
//
// Ports
//   clk              : single clock, rising edge
//   reset            : asynchronous, active-high
//   id_rn / id_rm    : ID source registers
//   id_rn_used /
//   id_rm_used       : the matching source is actually read
//   id_rd            : ID destination register
//   id_reg_write     : ID instruction writes id_rd
//   id_mem_load      : ID instruction is a load
//   branch_taken     : taken branch resolved in ID this cycle
//   nop_insert       : 1 zeroes the ID control signals (bubble into EX)
//   pc_load_enable   : PC update enable
//   ifid_load_enable : IF/ID update enable
//   ifid_flush       : clear IF/ID at the next edge
//   fwd_a / fwd_b    : operand source, 00 regfile, 01 EX, 10 MEM, 11 WB
//   stall_cycles     : saturating count of load-use stall cycles
//   flush_count      : saturating count of IF/ID flushes
// ---------------------------------------------------------------------------
module hazard_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       id_rn,
   input  logic [3:0]       id_rm,
   input  logic             id_rn_used,
   input  logic             id_rm_used,
   input  logic [3:0]       id_rd,
   input  logic             id_reg_write,
   input  logic             id_mem_load,
   input  logic             branch_taken,
   output logic             nop_insert,
   output logic             pc_load_enable,
   output logic             ifid_load_enable,
   output logic             ifid_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Register 15 is the PC. It is never produced through the normal
   // write-back path, so it never forwards and never stalls.
   localparam logic [3:0] PC_REG = 4'd15;

   typedef struct packed {
      logic       valid;
      logic [3:0] rd;
      logic       reg_write;
      logic       is_load;
   } sb_entry_t;

   sb_entry_t ex_reg, mem_reg, wb_reg;
   sb_entry_t id_entry;
   sb_entry_t ex_next;

   logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
   logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;

   // Index 0 is Rn and index 1 is Rm, so both sources share one
   // generate loop.
   logic [1:0][3:0] src;
   logic [1:0]      src_used;
   logic [1:0]      hit_ex, hit_mem, hit_wb;
   logic [1:0][1:0] fwd_sel;

   logic load_use;

   function automatic logic src_match(input sb_entry_t e,
                                      input logic [3:0] s,
                                      input logic       used);
      return used && e.valid && e.reg_write && (e.rd == s) && (s != PC_REG);
   endfunction

   assign src[0]      = id_rn;
   assign src[1]      = id_rm;
   assign src_used[0] = id_rn_used;
   assign src_used[1] = id_rm_used;

   assign id_entry = '{valid: 1'b1, rd: id_rd,
                       reg_write: id_reg_write, is_load: id_mem_load};

   // ------------------------------------------------------------------
   // Per-source match and forward selection
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         assign hit_ex[gi]  = src_match(ex_reg,  src[gi], src_used[gi]);
         assign hit_mem[gi] = src_match(mem_reg, src[gi], src_used[gi]);
         assign hit_wb[gi]  = src_match(wb_reg,  src[gi], src_used[gi]);

         // The youngest producer wins. A load in EX has no data yet.
         // The stall covers that case, so this source reads the regfile
         // for now and picks up MEM forwarding on the following cycle.
         assign fwd_sel[gi] = reset                          ? 2'b00 :
                              (hit_ex[gi] && ex_reg.is_load) ? 2'b00 :
                              hit_ex[gi]                     ? 2'b01 :
                              hit_mem[gi]                    ? 2'b10 :
                              hit_wb[gi]                     ? 2'b11 :
                                                               2'b00;
      end
   endgenerate

   assign fwd_a = fwd_sel[0];
   assign fwd_b = fwd_sel[1];

   // ------------------------------------------------------------------
   // Stall / flush control (combinational, zero latency)
   // ------------------------------------------------------------------
   // While reset is held the scoreboard is already clear. The explicit
   // gating keeps the outputs at their idle values whatever ID presents.
   assign load_use = !reset && ex_reg.is_load && (|hit_ex);

   assign nop_insert       = load_use;
   assign pc_load_enable   = !load_use;
   assign ifid_load_enable = !load_use;

   // A stalled ID holds the branch, and the branch resolves again next
   // cycle. Flushing now would throw away the instruction behind it twice.
   assign ifid_flush = !reset && branch_taken && !load_use;

   // ------------------------------------------------------------------
   // Scoreboard shift
   // ------------------------------------------------------------------
   always_comb begin
      ex_next = id_entry;
      if (nop_insert) begin
         ex_next = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_reg  <= '0;
         mem_reg <= '0;
         wb_reg  <= '0;
      end else begin
         ex_reg  <= ex_next;
         mem_reg <= ex_reg;
         wb_reg  <= mem_reg;
      end
   end

   // ------------------------------------------------------------------
   // Saturating performance counters
   // ------------------------------------------------------------------
   always_comb begin
      stall_cnt_next = stall_cnt_reg;
      if (load_use && (stall_cnt_reg != CNT_MAX)) begin
         stall_cnt_next = stall_cnt_reg + CNT_ONE;
      end
   end

   always_comb begin
      flush_cnt_next = flush_cnt_reg;
      if (ifid_flush && (flush_cnt_reg != CNT_MAX)) begin
         flush_cnt_next = flush_cnt_reg + CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         stall_cnt_reg <= stall_cnt_next;
         flush_cnt_reg <= flush_cnt_next;
      end
   end

   assign stall_cycles = stall_cnt_reg;
   assign flush_count  = flush_cnt_reg;

endmodule
